// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style figure controller:
// FSM states, write phases, LCD command bytes and glyph-set sizes.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_READY,
    ST_INIT,
    ST_CG_LOAD,
    ST_DD_WRITE,
    ST_IDLE
  } lcd_state_e;

  typedef enum logic [1:0] {
    PH_SETUP,
    PH_EN,
    PH_WAIT
  } wr_phase_e;

  localparam logic [7:0] CMD_FUNC_SET   = 8'h38;
  localparam logic [7:0] CMD_DISP_ON    = 8'h0C;
  localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;
  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_CGRAM_ADDR = 8'h40;
  localparam logic [7:0] CMD_DDRAM_L1   = 8'h80;
  localparam logic [7:0] CMD_DDRAM_L2   = 8'hC0;

  localparam int NUM_FACES      = 3;
  localparam int NUM_INDICATORS = 4;

  localparam logic FIG_FACE = 1'b0;
  localparam logic FIG_IND  = 1'b1;

endpackage

// File: rtl/lcd_glyph_rom.sv
// Combinational glyph store: each figure is four 5x8 glyphs forming a 2x2 tile.
// Out-of-range figure indices read back as a blank glyph.
module lcd_glyph_rom
  import lcd_pkg::*;
#(
  parameter int IDX_W = 2
) (
  input  logic             fig_class,
  input  logic [IDX_W-1:0] fig_idx,
  input  logic [1:0]       glyph,
  input  logic [2:0]       row,
  output logic [7:0]       row_data
);

  // One 64-bit word per glyph, row 0 in the top byte.
  localparam logic [63:0] FACE_GLYPHS [NUM_FACES*4] = '{
    64'h00030408_0A080904, 64'h00180402_0A021204, 64'h04030000_00000000, 64'h04180000_00000000,
    64'h00030408_0A080808, 64'h00180402_0A020202, 64'h0F040300_00000000, 64'h1E041800_00000000,
    64'h00030408_0A080807, 64'h00180402_0A02021C, 64'h08040300_00000000, 64'h02041800_00000000
  };

  localparam logic [63:0] IND_GLYPHS [NUM_INDICATORS*4] = '{
    64'h0E111111_11111111, 64'h11111111_1111111F, 64'h1F000000_00000000, 64'h00000000_0000001F,
    64'h0E111111_11111F1F, 64'h1F1F1F1F_1F1F1F1F, 64'h1F000000_00000000, 64'h00000000_0000001F,
    64'h0E11111F_1F1F1F1F, 64'h1F1F1F1F_1F1F1F1F, 64'h1F100000_00000000, 64'h00000000_0000011F,
    64'h000A1F1F_1F0E0400, 64'h040E1F1F_0E040000, 64'h00110A04_0A110000, 64'h1F1F1F1F_1F1F1F1F
  };

  logic [31:0] idx_ext;
  logic [63:0] bitmap;
  logic [7:0]  raw;

  always_comb begin
    idx_ext = 32'(fig_idx);
    bitmap  = '0;
    if (fig_class == FIG_FACE) begin
      if (idx_ext < NUM_FACES) bitmap = FACE_GLYPHS[{idx_ext[1:0], glyph}];
    end else begin
      if (idx_ext < NUM_INDICATORS) bitmap = IND_GLYPHS[{idx_ext[1:0], glyph}];
    end
    raw      = bitmap[{3'd7 - row, 3'b000} +: 8];
    row_data = {3'b000, raw[4:0]};
  end

endmodule

// File: rtl/lcd_figure_ctrl.sv
// Character-LCD controller: initialises the panel, loads a face and an indicator
// figure into CGRAM and places them on screen, redrawing when the selection changes.
module lcd_figure_ctrl
  import lcd_pkg::*;
#(
  parameter int EN_CYCLES  = 2,
  parameter int CMD_WAIT   = 50,
  parameter int CLEAR_WAIT = 2000,
  parameter int FIG1_W     = 2,
  parameter int FIG2_W     = 2,
  parameter int COL2       = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ready_i,
  input  logic [FIG1_W+FIG2_W-1:0] select_figures,
  output logic                     rs,
  output logic                     rw,
  output logic                     enable,
  output logic [7:0]               data,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int SEL_W    = FIG1_W + FIG2_W;
  localparam int IDX_W    = (FIG1_W > FIG2_W) ? FIG1_W : FIG2_W;
  localparam int MAX_WAIT = (CMD_WAIT > CLEAR_WAIT) ? CMD_WAIT : CLEAR_WAIT;
  localparam int MAX_T    = (EN_CYCLES > MAX_WAIT) ? EN_CYCLES : MAX_WAIT;
  localparam int CNT_W    = $clog2(MAX_T + 1);

  localparam logic [CNT_W-1:0] EN_LAST = CNT_W'(EN_CYCLES - 1);
  localparam logic [6:0] INIT_LAST = 7'd3;
  localparam logic [6:0] CG_LAST   = 7'd64;
  localparam logic [6:0] DD_LAST   = 7'd11;

  lcd_state_e       state_q, state_d;
  wr_phase_e        phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       step_q, step_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             frame_done_q, frame_done_d;

  logic             writing;
  logic             cmd_rs;
  logic [7:0]       cmd_data;
  logic             last_step;
  logic [CNT_W-1:0] wait_len;
  logic             write_done;

  logic [5:0]       cg_k;
  logic [IDX_W-1:0] face_idx, ind_idx;
  logic [7:0]       rom_row;

  // CGRAM byte k: slot k[5:3] (face 0-3, indicator 4-7), row k[2:0]
  assign cg_k     = 6'(step_q - 7'd1);
  assign face_idx = IDX_W'(sel_q[SEL_W-1:FIG2_W]);
  assign ind_idx  = IDX_W'(sel_q[FIG2_W-1:0]);

  lcd_glyph_rom #(.IDX_W(IDX_W)) u_rom (
    .fig_class (cg_k[5]),
    .fig_idx   (cg_k[5] ? ind_idx : face_idx),
    .glyph     (cg_k[4:3]),
    .row       (cg_k[2:0]),
    .row_data  (rom_row)
  );

  assign writing = (state_q == ST_INIT) || (state_q == ST_CG_LOAD) || (state_q == ST_DD_WRITE);

  always_comb begin
    cmd_rs    = 1'b0;
    cmd_data  = 8'h00;
    last_step = 1'b0;
    wait_len  = CNT_W'(CMD_WAIT);
    case (state_q)
      ST_INIT: begin
        case (step_q[1:0])
          2'd0:    cmd_data = CMD_FUNC_SET;
          2'd1:    cmd_data = CMD_DISP_ON;
          2'd2:    cmd_data = CMD_ENTRY_MODE;
          default: cmd_data = CMD_CLEAR;
        endcase
        last_step = (step_q == INIT_LAST);
        if (step_q == INIT_LAST) wait_len = CNT_W'(CLEAR_WAIT);
      end
      ST_CG_LOAD: begin
        if (step_q == 7'd0) begin
          cmd_data = CMD_CGRAM_ADDR;
        end else begin
          cmd_rs   = 1'b1;
          cmd_data = rom_row;
        end
        last_step = (step_q == CG_LAST);
      end
      ST_DD_WRITE: begin
        // Character codes 0-7 point at the CGRAM slots loaded above
        cmd_rs = 1'b1;
        case (step_q)
          7'd0:    begin cmd_rs = 1'b0; cmd_data = CMD_DDRAM_L1; end
          7'd1:    cmd_data = 8'h00;
          7'd2:    cmd_data = 8'h01;
          7'd3:    begin cmd_rs = 1'b0; cmd_data = CMD_DDRAM_L1 + 8'(COL2); end
          7'd4:    cmd_data = 8'h04;
          7'd5:    cmd_data = 8'h05;
          7'd6:    begin cmd_rs = 1'b0; cmd_data = CMD_DDRAM_L2; end
          7'd7:    cmd_data = 8'h02;
          7'd8:    cmd_data = 8'h03;
          7'd9:    begin cmd_rs = 1'b0; cmd_data = CMD_DDRAM_L2 + 8'(COL2); end
          7'd10:   cmd_data = 8'h06;
          default: cmd_data = 8'h07;
        endcase
        last_step = (step_q == DD_LAST);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    step_d       = step_q;
    sel_d        = sel_q;
    frame_done_d = 1'b0;
    write_done   = 1'b0;
    case (state_q)
      ST_WAIT_READY: begin
        if (ready_i) begin
          state_d = ST_INIT;
          phase_d = PH_SETUP;
          cnt_d   = '0;
          step_d  = '0;
        end
      end
      ST_IDLE: begin
        if (select_figures != sel_q) begin
          state_d = ST_CG_LOAD;
          sel_d   = select_figures;
          phase_d = PH_SETUP;
          cnt_d   = '0;
          step_d  = '0;
        end
      end
      default: begin
        case (phase_q)
          PH_SETUP: begin
            phase_d = PH_EN;
            cnt_d   = '0;
          end
          PH_EN: begin
            if (cnt_q == EN_LAST) begin
              cnt_d = '0;
              if (wait_len == '0) write_done = 1'b1;
              else                phase_d    = PH_WAIT;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: begin
            if (cnt_q == wait_len - 1'b1) write_done = 1'b1;
            else                          cnt_d      = cnt_q + 1'b1;
          end
        endcase
        if (write_done) begin
          phase_d = PH_SETUP;
          cnt_d   = '0;
          step_d  = step_q + 7'd1;
          if (last_step) begin
            step_d = '0;
            case (state_q)
              ST_INIT: begin
                state_d = ST_CG_LOAD;
                sel_d   = select_figures;
              end
              ST_CG_LOAD: state_d = ST_DD_WRITE;
              default: begin
                state_d      = ST_IDLE;
                frame_done_d = 1'b1;
              end
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_WAIT_READY;
      phase_q      <= PH_SETUP;
      cnt_q        <= '0;
      step_q       <= '0;
      sel_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      step_q       <= step_d;
      sel_q        <= sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign rs         = writing & cmd_rs;
  assign data       = writing ? cmd_data : 8'h00;
  assign enable     = writing && (phase_q == PH_EN);
  assign rw         = 1'b0;
  assign busy       = writing;
  assign frame_done = frame_done_q;

endmodule
